// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state types and single-cycle result function for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_SLTU = 4'h6,
        OP_SLL  = 4'h7,
        OP_SRL  = 4'h8,
        OP_SRA  = 4'h9,
        OP_MUL  = 4'hA,
        OP_DIV  = 4'hB,
        OP_DIVU = 4'hC,
        OP_REM  = 4'hD,
        OP_REMU = 4'hE,
        OP_ILL  = 4'hF
    } opc_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_ITER = 2'd1,
        ST_DIV_ITER = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] res;
        logic        err;
    } sc_res_t;

    // Operands arrive widened to 64 bits; the caller keeps the low WIDTH bits of res.
    function automatic sc_res_t alu_single(input opc_e op, input logic [63:0] a_s,
                                           input logic [63:0] b_s, input logic [63:0] a_u,
                                           input logic [5:0] sh);
        sc_res_t r;
        r.res = '0;
        r.err = 1'b0;
        case (op)
            OP_ADD:  r.res = a_s + b_s;
            OP_SUB:  r.res = a_s - b_s;
            OP_AND:  r.res = a_s & b_s;
            OP_OR:   r.res = a_s | b_s;
            OP_XOR:  r.res = a_s ^ b_s;
            OP_SLT:  r.res = {63'd0, $signed(a_s) < $signed(b_s)};
            OP_SLTU: r.res = {63'd0, a_s < b_s};
            OP_SLL:  r.res = a_s << sh;
            OP_SRL:  r.res = a_u >> sh;
            OP_SRA:  r.res = $signed(a_s) >>> sh;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/ready/valid request and result bundle of alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] w;
    logic             zero;
    logic             neg;
    logic             err;

    modport master (
        output start, opc, a, b,
        input  in_ready, out_valid, w, zero, neg, err
    );

    modport slave (
        input  start, opc, a, b,
        output in_ready, out_valid, w, zero, neg, err
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiply and restoring divide
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  opc_e             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_is_mul, r_is_rem, r_neg_q, r_neg_r;
    logic [WIDTH-1:0] r_acc, r_shr, r_opnd;

    logic             w_sa, w_sb, w_ge;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_acc_nx, w_shr_nx, w_opnd_nx;
    logic [WIDTH:0]   w_rem_sh;

    always_comb begin
        w_sa    = ((i_op == OP_DIV) || (i_op == OP_REM)) && i_a[WIDTH-1];
        w_sb    = ((i_op == OP_DIV) || (i_op == OP_REM)) && i_b[WIDTH-1];
        w_mag_a = w_sa ? -i_a : i_a;
        w_mag_b = w_sb ? -i_b : i_b;
    end

    // Multiply: r_acc accumulates, r_shr holds the multiplier, r_opnd the shifted multiplicand.
    // Divide: r_acc is the partial remainder, r_shr shifts the dividend out and the quotient in.
    always_comb begin
        w_rem_sh = {r_acc, r_shr[WIDTH-1]};
        w_ge     = w_rem_sh >= {1'b0, r_opnd};
        if (r_is_mul) begin
            w_acc_nx  = r_shr[0] ? r_acc + r_opnd : r_acc;
            w_shr_nx  = r_shr >> 1;
            w_opnd_nx = r_opnd << 1;
        end else begin
            w_acc_nx  = w_ge ? w_rem_sh[WIDTH-1:0] - r_opnd : w_rem_sh[WIDTH-1:0];
            w_shr_nx  = {r_shr[WIDTH-2:0], w_ge};
            w_opnd_nx = r_opnd;
        end
        if (r_is_mul)
            o_result = w_acc_nx;
        else if (r_is_rem)
            o_result = r_neg_r ? -w_acc_nx : w_acc_nx;
        else
            o_result = r_neg_q ? -w_shr_nx : w_shr_nx;
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_shr    <= '0;
            r_opnd   <= '0;
        end else if (i_go) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_mul <= (i_op == OP_MUL);
            r_is_rem <= (i_op == OP_REM) || (i_op == OP_REMU);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_acc    <= '0;
            r_shr    <= (i_op == OP_MUL) ? i_b : w_mag_a;
            r_opnd   <= (i_op == OP_MUL) ? i_a : w_mag_b;
        end else if (r_busy) begin
            r_acc  <= w_acc_nx;
            r_shr  <= w_shr_nx;
            r_opnd <= w_opnd_nx;
            r_cnt  <= r_cnt + 1'b1;
            if (o_done)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered execute unit; RV-M mul/div built only when ALU_MULDIV_EN is defined
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    state_e           r_state;
    logic [WIDTH-1:0] r_w;
    logic             r_zero, r_neg, r_err, r_valid;

    sc_res_t          w_sc;
    logic [WIDTH-1:0] w_imm, w_nxt;
    logic             w_imm_err, w_nxt_err, w_accept, w_upd;

    assign w_accept = bus.start && (r_state == ST_IDLE);

    if (WIDTH < 64) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_sc.res[63:WIDTH];
    end

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_md_go, w_md_busy, w_md_done, w_md_fin;
    logic [WIDTH-1:0] w_md_res;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_go     (w_accept && w_md_go),
        .i_op     (opc_e'(bus.opc)),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_res)
    );

    assign w_md_fin = w_md_busy && w_md_done;
`endif

    always_comb begin
        w_sc      = alu_single(opc_e'(bus.opc), 64'($signed(bus.a)), 64'($signed(bus.b)),
                               64'(bus.a), 6'(bus.b[SHW-1:0]));
        w_imm     = w_sc.res[WIDTH-1:0];
        w_imm_err = w_sc.err;
        w_upd     = w_accept;
`ifdef ALU_MULDIV_EN
        w_md_go = 1'b0;
        // Divide-by-zero and MIN/-1 resolve immediately instead of iterating.
        if (bus.opc >= OP_MUL && bus.opc <= OP_REMU) begin
            w_imm_err = 1'b0;
            if (bus.opc == OP_MUL)
                w_md_go = 1'b1;
            else if (bus.b == '0)
                w_imm = (bus.opc == OP_DIV || bus.opc == OP_DIVU) ? '1 : bus.a;
            else if ((bus.opc == OP_DIV || bus.opc == OP_REM) && bus.a == MIN && bus.b == '1)
                w_imm = (bus.opc == OP_DIV) ? MIN : '0;
            else
                w_md_go = 1'b1;
        end
        w_upd = (w_accept && !w_md_go) || w_md_fin;
`endif
        w_nxt     = w_imm;
        w_nxt_err = w_imm_err;
`ifdef ALU_MULDIV_EN
        if (w_md_fin) begin
            w_nxt     = w_md_res;
            w_nxt_err = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
`ifdef ALU_MULDIV_EN
            if (w_accept && w_md_go)
                r_state <= (bus.opc == OP_MUL) ? ST_MUL_ITER : ST_DIV_ITER;
            else if (w_md_fin)
                r_state <= ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w     <= '0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_upd;
            if (w_upd) begin
                r_w    <= w_nxt;
                r_zero <= (w_nxt == '0);
                r_neg  <= w_nxt[WIDTH-1];
                r_err  <= w_nxt_err;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.w         = r_w;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - vector table, directed corner sequences and random ops against a reference model
module tb_alu_seq;
    localparam int WIDTH = 32;
    localparam int MULTI = WIDTH + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] w;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [3:0] opc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] w, input logic err);
        vec_t v;
        v.name = name; v.opc = opc; v.a = a; v.b = b; v.w = w; v.err = err; v.lat = 1;
        return v;
    endfunction

    function automatic vec_t mkmd(input string name, input logic [3:0] opc, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] w, input int lat);
        vec_t v;
        v = mk(name, opc, a, b, 32'd0, 1'b1);
`ifdef ALU_MULDIV_EN
        v.w = w; v.err = 1'b0; v.lat = lat;
`endif
        return v;
    endfunction

    function automatic void ref_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] w, output logic err, output int lat);
        int          sa, sb;
        logic [4:0]  sh;
        sa = a; sb = b; sh = b[4:0];
        w = 32'd0; err = 1'b0; lat = 1;
        case (opc)
            4'h0: w = a + b;
            4'h1: w = a - b;
            4'h2: w = a & b;
            4'h3: w = a | b;
            4'h4: w = a ^ b;
            4'h5: w = (sa < sb) ? 32'd1 : 32'd0;
            4'h6: w = (a < b) ? 32'd1 : 32'd0;
            4'h7: w = a << sh;
            4'h8: w = a >> sh;
            4'h9: w = sa >>> sh;
            default: err = 1'b1;
        endcase
`ifdef ALU_MULDIV_EN
        if (opc >= 4'hA && opc <= 4'hE) begin
            err = 1'b0;
            if (opc == 4'hA) begin
                w = a * b; lat = MULTI;
            end else if (b == 32'd0) begin
                w = (opc == 4'hB || opc == 4'hC) ? 32'hFFFF_FFFF : a;
            end else if ((opc == 4'hB || opc == 4'hD) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                w = (opc == 4'hB) ? 32'h8000_0000 : 32'd0;
            end else begin
                lat = MULTI;
                case (opc)
                    4'hB:    w = sa / sb;
                    4'hC:    w = a / b;
                    4'hD:    w = sa % sb;
                    default: w = a % b;
                endcase
            end
        end
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scramble();
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.opc = 4'($urandom);
    endtask

    // Waits for in_ready, issues one op, scrambles the inputs, then checks latency and result.
    task automatic do_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ew, input logic eerr, input int elat);
        int n, lowrdy;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready before issue"}, 32'(bus.in_ready), 32'd1);
        bus.start = 1'b1; bus.opc = opc; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        n = 1; lowrdy = 0;
        while (!bus.out_valid && n < 200) begin
            if (!bus.in_ready) lowrdy++;
            @(negedge clk);
            scramble();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(elat));
        chk({tag, " in_ready low cycles"}, 32'(lowrdy), 32'(elat - 1));
        chk({tag, " w"}, bus.w, ew);
        chk({tag, " zero"}, 32'(bus.zero), 32'(ew == 32'd0));
        chk({tag, " neg"}, 32'(bus.neg), 32'(ew[31]));
        chk({tag, " err"}, 32'(bus.err), 32'(eerr));
        chk({tag, " in_ready at completion"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " w"}, bus.w, 32'd0);
        chk({tag, " zero"}, 32'(bus.zero), 32'd1);
        chk({tag, " neg"}, 32'(bus.neg), 32'd0);
        chk({tag, " err"}, 32'(bus.err), 32'd0);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rw, ra, rb;
        logic        rerr;
        int          rlat, n, seen;

        bus.start = 1'b0; bus.opc = 4'h0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("after reset");

        vecs.push_back(mk("ADD 5+-7",   4'h0, 32'd5,          32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0));
        vecs.push_back(mk("SUB equal",  4'h1, 32'h1234,       32'h1234,      32'd0,         1'b0));
        vecs.push_back(mk("AND",        4'h2, 32'hF0F0_1234,  32'hFF00_FF00, 32'hF000_1200, 1'b0));
        vecs.push_back(mk("OR",         4'h3, 32'h0000_00F0,  32'h0F00_000F, 32'h0F00_00FF, 1'b0));
        vecs.push_back(mk("XOR",        4'h4, 32'hAAAA_AAAA,  32'hFFFF_FFFF, 32'h5555_5555, 1'b0));
        vecs.push_back(mk("SLT -1<1",   4'h5, 32'hFFFF_FFFF,  32'd1,         32'd1,         1'b0));
        vecs.push_back(mk("SLTU big<1", 4'h6, 32'hFFFF_FFFF,  32'd1,         32'd0,         1'b0));
        vecs.push_back(mk("SLL shamt",  4'h7, 32'd1,          32'h0000_0023, 32'd8,         1'b0));
        vecs.push_back(mk("SRL 31",     4'h8, 32'h8000_0000,  32'd31,        32'd1,         1'b0));
        vecs.push_back(mk("SRA 4",      4'h9, 32'h8000_0000,  32'd4,         32'hF800_0000, 1'b0));
        vecs.push_back(mk("ILLEGAL",    4'hF, 32'd123,        32'd456,       32'd0,         1'b1));
        vecs.push_back(mkmd("MUL",      4'hA, 32'd12345,      32'd6789,      32'd83810205,  MULTI));
        vecs.push_back(mkmd("DIV -7/2", 4'hB, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, MULTI));
        vecs.push_back(mkmd("REM -7%2", 4'hD, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, MULTI));
        vecs.push_back(mkmd("DIVU",     4'hC, 32'd100,        32'd7,         32'd14,        MULTI));
        vecs.push_back(mkmd("REMU",     4'hE, 32'd100,        32'd7,         32'd2,         MULTI));
        vecs.push_back(mkmd("DIV by 0", 4'hB, 32'd9,          32'd0,         32'hFFFF_FFFF, 1));
        vecs.push_back(mkmd("REM by 0", 4'hD, 32'd9,          32'd0,         32'd9,         1));
        vecs.push_back(mkmd("DIV ovf",  4'hB, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1));
        vecs.push_back(mkmd("REM ovf",  4'hD, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1));

        for (int i = 0; i < vecs.size(); i++)
            do_op(vecs[i].name, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].err, vecs[i].lat);

        bus.start = 1'b0;
        @(negedge clk);
        chk("single pulse out_valid", 32'(bus.out_valid), 32'd0);

`ifdef ALU_MULDIV_EN
        // ADD requests held high during MUL iteration must be dropped.
        bus.start = 1'b1; bus.opc = 4'hA; bus.a = 32'd12345; bus.b = 32'd6789;
        @(negedge clk);
        bus.opc = 4'h0; bus.a = 32'd1; bus.b = 32'd2;
        n = 1;
        repeat (10) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("MUL with ignored starts latency", 32'(n), 32'(MULTI));
        chk("MUL with ignored starts w", bus.w, 32'd83810205);
        bus.start = 1'b1; bus.opc = 4'h0; bus.a = 32'd7; bus.b = 32'd8;
        @(negedge clk);
        bus.start = 1'b0;
        chk("back-to-back out_valid", 32'(bus.out_valid), 32'd1);
        chk("back-to-back w", bus.w, 32'd15);
        @(negedge clk);
        chk("back-to-back pulse end", 32'(bus.out_valid), 32'd0);
`endif

        do_op("pre-reset ADD", 4'h0, 32'd5, 32'd6, 32'd11, 1'b0, 1);
        ref_op(4'hC, 32'd100, 32'd7, rw, rerr, rlat);
        bus.start = 1'b1; bus.opc = 4'hC; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("mid-DIVU reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (WIDTH + 5) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("no out_valid after abort", 32'(seen), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = $urandom_range(0, 20);
                default: rb = $urandom;
            endcase
            ref_op(op, ra, rb, rw, rerr, rlat);
            do_op($sformatf("rand%0d op%h", i, op), op, ra, rb, rw, rerr, rlat);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk($sformatf("rand%0d pulse end", i), 32'(bus.out_valid), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
